keypad_scanner: RTL and testbench
=================================

Name: keypad_scanner

Overview:
Scans a 4x4 matrix keypad, the input-side counterpart of the time-multiplexed 7-segment display driver. It drives one column low per scan slot and samples the rows. It debounces complete matrix scans and emits one key code per debounced press. Its outputs feed the driver-control and mode logic, for example gear or mode selection.

Parameters:
DEBOUNCE_SCANS, 4, number of consecutive identical full-matrix scans needed to accept a press or a release. Legal range is 2..15.

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous, active-low reset
tick_scan  input  1  1-clk strobe that advances the column slot; strobes are at least 3 clk apart
key_row  input  4  raw row lines, active-low, externally pulled up, asynchronous to clk
key_col  output  4  column drive, active-low, exactly one bit low at any time
key_code  output  4  last accepted key, code = row*4 + col
key_valid  output  1  1-clk pulse when a new press is accepted
key_held  output  1  high while the accepted key is debounced-pressed
multi_key  output  1  high when the most recent completed scan had 2 or more keys down

Behaviour:
- Reset (asynchronous, rst_n=0):
  - col_idx=0, so key_col=4'b1110.
  - Row synchronizer = 4'hF.
  - Scan accumulator cleared, state=IDLE, counter=0.
  - key_code=0, key_valid=0, key_held=0, multi_key=0.
- Row synchronizer: 2-flop, key_row -> row_s. Only row_s is used internally.
- Key mapping: key (r,c) is down when key_col[c]=0 and row_s[r]=0.
- Scan timing:
  - On tick_scan, record ~row_s into the accumulator bits for the current col_idx, then advance col_idx = col_idx+1 mod 4. key_col follows col_idx.
  - The tick at col_idx=3 completes a scan. In the next clk, a registered scan_done is asserted with a result:
    - NONE: 0 keys down.
    - SINGLE(K): exactly 1 key down.
    - MULTI: 2 or more keys down.
  - multi_key is updated at scan_done. The accumulator clears for the next scan.
- FSM: states IDLE, DEB_PRESS, PRESSED, DEB_REL. Evaluated only in scan_done cycles; otherwise the FSM holds. cnt is a 4-bit counter.
  - IDLE:
    - SINGLE(K): cand<=K, cnt<=1, go to DEB_PRESS.
    - NONE or MULTI: stay.
  - DEB_PRESS:
    - SINGLE(cand): cnt<=cnt+1. When cnt+1==DEBOUNCE_SCANS, go to PRESSED and set key_code<=cand, key_valid<=1 for one clk, key_held<=1.
    - SINGLE(other): cand<=other, cnt<=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED:
    - SINGLE(cand): stay.
    - Anything else: cnt<=1, go to DEB_REL.
  - DEB_REL:
    - SINGLE(cand): return to PRESSED. No new key_valid is issued.
    - Anything else: cnt<=cnt+1. When cnt+1==DEBOUNCE_SCANS, go to IDLE and set key_held<=0.
- key_valid latency: high exactly in the clk after the scan_done that qualifies, i.e. 2 clk after the col-3 tick_scan of the qualifying scan.
- key_code holds its value until the next accepted press. It does not change on release.
- Any 2-or-more-key pattern (MULTI) is treated as no valid key. This rejects ghosting.
- A press of a different key while in PRESSED first requires a debounced release through DEB_REL to IDLE. Only then can the new key be accepted. There is no rollover.
- Reset mid-operation: all state is discarded immediately and no key_valid is produced. Scanning restarts at column 0 after reset is released.
- tick_scan asserted in the same clk as scan_done: the tick is processed normally, since the accumulator clear and the first column write do not conflict.

Decomposition:
- Shared package:
  - FSM state enum.
  - KEY_ROWS=4 and KEY_COLS=4.
  - Result encoding: NONE, SINGLE, MULTI.
- One natural sub-module: keypad_matrix_scan. It covers the synchronizer, column counter, accumulator, and the scan_done/result encoder. The debounce FSM stays in the top level.

Test Plan:
All scenarios use tick_scan every 10 clk (1 scan = 40 clk) and DEBOUNCE_SCANS=4.
1. Reset: assert rst_n=0 mid-scan -> key_col=4'b1110 and all outputs 0 during and after reset. After release, key_col steps 1110 -> 1101 -> 1011 -> 0111 -> 1110 on successive ticks.
2. Clean press: hold key row1/col2 for 8 scans -> exactly one key_valid, 2 clk after the 4th scan's col-3 tick. key_code=6 and key_held=1 thereafter.
3. Press bounce: key 6 down for 2 scans, up for 1, down for 5 -> one key_valid only, at the 4th scan of the final run.
4. Ghost/multi: keys 0 and 5 down for 6 scans -> multi_key=1 and no key_valid. Release 0, leaving 5 down -> key_valid with key_code=5 after 4 scans.
5. Release bounce: from PRESSED on key 6, release for 2 scans then re-press -> key_held stays 1 with no new key_valid. Then release for 4 scans -> key_held=0 and key_code stays 6.
6. Reset in DEB_PRESS: key 6 down for 3 scans, pulse rst_n low -> no key_valid. The 4-scan count restarts from 0 after reset.

Source files
------------

// File: rtl/keypad_scanner_pkg.sv
// Shared definitions for the 4x4 matrix keypad scanner.
// Contents: matrix geometry, the debounce FSM state type, the per-scan result
// encoding, and a helper that classifies one full-matrix snapshot.
package keypad_scanner_pkg;

    localparam int unsigned KEY_ROWS = 4;
    localparam int unsigned KEY_COLS = 4;
    localparam int unsigned KEY_NUM  = KEY_ROWS * KEY_COLS;

    typedef enum logic [1:0] {
        StIdle,
        StDebPress,
        StPressed,
        StDebRel
    } state_e;

    typedef enum logic [1:0] {
        ResNone,
        ResSingle,
        ResMulti
    } scan_res_e;

    typedef struct packed {
        scan_res_e  res;
        logic [3:0] code;
    } scan_result_t;

    // Snapshot bit index is row*KEY_COLS + col, which is also the key code.
    function automatic scan_result_t classify(input logic [KEY_NUM-1:0] keys);
        scan_result_t result;
        logic [4:0]   num_down;
        logic [3:0]   code;
        num_down = '0;
        code     = '0;
        for (int i = 0; i < KEY_NUM; i++) begin
            if (keys[i]) begin
                num_down = num_down + 5'd1;
                code     = 4'(i);
            end
        end
        if (num_down == 5'd0) begin
            result.res  = ResNone;
            result.code = '0;
        end else if (num_down == 5'd1) begin
            result.res  = ResSingle;
            result.code = code;
        end else begin
            result.res  = ResMulti;
            result.code = '0;
        end
        return result;
    endfunction

endpackage

// File: rtl/keypad_matrix_scan.sv
// Column scanner for the 4x4 keypad: synchronizes the rows, walks one low
// column per tick, accumulates a full-matrix snapshot and reports it.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick_scan    1-clk strobe, records the current column then advances
//   key_row      raw active-low row lines (asynchronous)
//   key_col      active-low column drive, one bit low
//   scan_done    1-clk pulse the clk after the column-3 tick
//   scan_res     scan_res_e encoding of the completed scan
//   scan_key     key code when scan_res is ResSingle, else 0
module keypad_matrix_scan
    import keypad_scanner_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                tick_scan,
    input  logic [KEY_ROWS-1:0] key_row,
    output logic [KEY_COLS-1:0] key_col,
    output logic                scan_done,
    output logic [1:0]          scan_res,
    output logic [3:0]          scan_key
);

    logic [KEY_ROWS-1:0] row_meta_q;
    logic [KEY_ROWS-1:0] row_s_q;
    logic [1:0]          col_idx_q;
    logic [KEY_NUM-1:0]  acc_q;
    logic [KEY_NUM-1:0]  acc_merged;
    logic                scan_done_q;
    scan_res_e           res_q;
    logic [3:0]          key_q;
    scan_result_t        cls;

    // Accumulator with the current column's rows folded in, so the column-3
    // tick can classify the complete scan in the same edge it is recorded.
    always_comb begin
        acc_merged = acc_q;
        for (int r = 0; r < KEY_ROWS; r++) begin
            for (int c = 0; c < KEY_COLS; c++) begin
                if (col_idx_q == 2'(c)) begin
                    acc_merged[r * KEY_COLS + c] = ~row_s_q[r];
                end
            end
        end
        cls = classify(acc_merged);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_meta_q  <= '1;
            row_s_q     <= '1;
            col_idx_q   <= '0;
            acc_q       <= '0;
            scan_done_q <= 1'b0;
            res_q       <= ResNone;
            key_q       <= '0;
        end else begin
            row_meta_q  <= key_row;
            row_s_q     <= row_meta_q;
            scan_done_q <= 1'b0;
            if (tick_scan) begin
                col_idx_q <= col_idx_q + 2'd1;
                if (col_idx_q == 2'd3) begin
                    acc_q       <= '0;
                    scan_done_q <= 1'b1;
                    res_q       <= cls.res;
                    key_q       <= cls.code;
                end else begin
                    acc_q <= acc_merged;
                end
            end
        end
    end

    always_comb begin
        key_col = ~(4'b0001 << col_idx_q);
    end

    assign scan_done = scan_done_q;
    assign scan_res  = res_q;
    assign scan_key  = key_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner with whole-scan debouncing. Emits one key code
// per debounced press; multi-key scans are treated as no key (anti-ghosting).
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   tick_scan    1-clk strobe advancing the column slot (>= 3 clk apart)
//   key_row      raw active-low row lines
//   key_col      active-low column drive, one bit low
//   key_code     last accepted key, row*4 + col
//   key_valid    1-clk pulse on each accepted press
//   key_held     high while the accepted key is debounced-pressed
//   multi_key    high when the last completed scan had 2+ keys down
module keypad_scanner
    import keypad_scanner_pkg::*;
#(
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_scan,
    input  logic [3:0] key_row,
    output logic [3:0] key_col,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held,
    output logic       multi_key
);

    localparam logic [3:0] DebTarget = 4'(DEBOUNCE_SCANS);

    logic       scan_done;
    logic [1:0] scan_res;
    logic [3:0] scan_key;

    state_e     state_q;
    logic [3:0] cnt_q;
    logic [3:0] cnt_inc;
    logic [3:0] cand_q;
    logic [3:0] key_code_q;
    logic       key_valid_q;
    logic       key_held_q;
    logic       multi_key_q;
    logic       is_single;
    logic       is_cand;

    keypad_matrix_scan u_scan (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_scan (tick_scan),
        .key_row   (key_row),
        .key_col   (key_col),
        .scan_done (scan_done),
        .scan_res  (scan_res),
        .scan_key  (scan_key)
    );

    assign cnt_inc   = cnt_q + 4'd1;
    assign is_single = (scan_res == ResSingle);
    assign is_cand   = is_single && (scan_key == cand_q);

    // Debounce FSM; only scan_done cycles move it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            cand_q      <= '0;
            key_code_q  <= '0;
            key_valid_q <= 1'b0;
            key_held_q  <= 1'b0;
            multi_key_q <= 1'b0;
        end else begin
            key_valid_q <= 1'b0;
            if (scan_done) begin
                multi_key_q <= (scan_res == ResMulti);
                case (state_q)
                    StIdle: begin
                        if (is_single) begin
                            cand_q  <= scan_key;
                            cnt_q   <= 4'd1;
                            state_q <= StDebPress;
                        end
                    end
                    StDebPress: begin
                        if (is_cand) begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == DebTarget) begin
                                state_q     <= StPressed;
                                key_code_q  <= cand_q;
                                key_valid_q <= 1'b1;
                                key_held_q  <= 1'b1;
                            end
                        end else if (is_single) begin
                            // A different single key restarts the count on it.
                            cand_q <= scan_key;
                            cnt_q  <= 4'd1;
                        end else begin
                            state_q <= StIdle;
                        end
                    end
                    StPressed: begin
                        if (!is_cand) begin
                            cnt_q   <= 4'd1;
                            state_q <= StDebRel;
                        end
                    end
                    StDebRel: begin
                        if (is_cand) begin
                            // Release bounce: back to held without a new press.
                            state_q <= StPressed;
                        end else begin
                            cnt_q <= cnt_inc;
                            if (cnt_inc == DebTarget) begin
                                state_q    <= StIdle;
                                key_held_q <= 1'b0;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign key_held  = key_held_q;
    assign multi_key = multi_key_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed bench for keypad_scanner: a keypad model answers the column drive
// from a pressed-key mask; one scan = 4 ticks, 10 clk apart.
module tb_keypad_scanner;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_scan;
    logic [3:0] key_row;
    logic [3:0] key_col;
    logic [3:0] key_code;
    logic       key_valid;
    logic       key_held;
    logic       multi_key;

    logic [15:0] keys;
    int          n_total = 0;
    int          n_bad   = 0;
    int          n_valid = 0;
    int          base;
    logic [1:0]  vpair;
    logic [3:0]  col_seq [4];

    always #5 clk = ~clk;

    keypad_scanner #(
        .DEBOUNCE_SCANS (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .tick_scan (tick_scan),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_code  (key_code),
        .key_valid (key_valid),
        .key_held  (key_held),
        .multi_key (multi_key)
    );

    // Keypad: row r pulled low when a pressed key in row r sits on the low column.
    always_comb begin
        for (int r = 0; r < 4; r++) begin
            key_row[r] = ~|(keys[r*4 +: 4] & ~key_col);
        end
    end

    always @(posedge clk) begin
        if (rst_n && key_valid) n_valid <= n_valid + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick_once(input int gap);
        repeat (gap) @(negedge clk);
        tick_scan = 1'b1;
        @(negedge clk);
        tick_scan = 1'b0;
    endtask

    // One full scan with the given mask; checks key_valid in the scan_done
    // cycle (must be 0) and the following cycle (must equal exp_valid).
    task automatic run_scan(input logic [15:0] mask, input logic exp_valid, input string tag);
        keys = mask;
        for (int c = 0; c < 4; c++) tick_once(c == 0 ? 8 : 9);
        vpair[1] = key_valid;
        @(negedge clk);
        vpair[0] = key_valid;
        check(tag, {30'b0, vpair}, {31'b0, exp_valid});
    endtask

    task automatic settle();
        repeat (2) @(negedge clk);
    endtask

    initial begin
        col_seq   = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};
        rst_n     = 1'b0;
        tick_scan = 1'b0;
        keys      = '0;

        // 1. reset values and column stepping
        repeat (3) @(negedge clk);
        check("rst_col", key_col, 4'b1110);
        check("rst_outs", {key_code, key_valid, key_held, multi_key}, 7'h00);
        rst_n = 1'b1;
        check("col_start", key_col, 4'b1110);
        for (int i = 0; i < 4; i++) begin
            tick_once(9);
            check("col_step", key_col, col_seq[i]);
        end
        keys = 16'h0040;
        tick_once(9);
        tick_once(9);
        rst_n = 1'b0;
        #1;
        check("midrst_col", key_col, 4'b1110);
        check("midrst_outs", {key_code, key_valid, key_held, multi_key}, 7'h00);
        repeat (3) @(negedge clk);
        check("midrst_hold", {key_col, key_code, key_valid, key_held, multi_key}, 11'h700);
        keys  = '0;
        rst_n = 1'b1;
        check("postrst_col", key_col, 4'b1110);

        // 2. clean press of key 6
        base = n_valid;
        for (int s = 0; s < 8; s++) run_scan(16'h0040, s == 3, "press6_valid");
        settle();
        check("press6_count", n_valid - base, 1);
        check("press6_code", key_code, 4'd6);
        check("press6_held", key_held, 1'b1);
        check("press6_multi", multi_key, 1'b0);

        // 5. release bounce, then a clean release
        base = n_valid;
        run_scan(16'h0000, 1'b0, "relb_valid");
        check("relb_held1", key_held, 1'b1);
        run_scan(16'h0000, 1'b0, "relb_valid");
        check("relb_held2", key_held, 1'b1);
        run_scan(16'h0040, 1'b0, "relb_valid");
        check("relb_repress", key_held, 1'b1);
        for (int s = 0; s < 3; s++) run_scan(16'h0000, 1'b0, "rel_valid");
        check("rel_held3", key_held, 1'b1);
        run_scan(16'h0000, 1'b0, "rel_valid");
        check("rel_held4", key_held, 1'b0);
        check("rel_code", key_code, 4'd6);
        settle();
        check("rel_count", n_valid - base, 0);

        // 4. keys 0 and 5 together, then 5 alone
        base = n_valid;
        run_scan(16'h0021, 1'b0, "multi_valid");
        check("multi_flag", multi_key, 1'b1);
        for (int s = 0; s < 5; s++) run_scan(16'h0021, 1'b0, "multi_valid");
        check("multi_flag6", multi_key, 1'b1);
        check("multi_held", key_held, 1'b0);
        settle();
        check("multi_count", n_valid - base, 0);
        base = n_valid;
        run_scan(16'h0020, 1'b0, "key5_valid");
        check("key5_multi", multi_key, 1'b0);
        for (int s = 1; s < 4; s++) run_scan(16'h0020, s == 3, "key5_valid");
        settle();
        check("key5_count", n_valid - base, 1);
        check("key5_code", key_code, 4'd5);
        check("key5_held", key_held, 1'b1);
        for (int s = 0; s < 4; s++) run_scan(16'h0000, 1'b0, "key5_rel_valid");
        check("key5_rel_held", key_held, 1'b0);
        check("key5_rel_code", key_code, 4'd5);

        // 3. press bounce on key 6
        base = n_valid;
        run_scan(16'h0040, 1'b0, "pb_valid");
        run_scan(16'h0040, 1'b0, "pb_valid");
        run_scan(16'h0000, 1'b0, "pb_valid");
        for (int s = 0; s < 5; s++) run_scan(16'h0040, s == 3, "pb_valid");
        settle();
        check("pb_count", n_valid - base, 1);
        check("pb_code", key_code, 4'd6);
        for (int s = 0; s < 4; s++) run_scan(16'h0000, 1'b0, "pb_rel_valid");
        check("pb_rel_held", key_held, 1'b0);

        // 6. reset while debouncing a press
        base = n_valid;
        for (int s = 0; s < 3; s++) run_scan(16'h0040, 1'b0, "rdp_valid");
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rdp_rst_outs", {key_code, key_valid, key_held, multi_key}, 7'h00);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) run_scan(16'h0040, s == 3, "rdp_valid");
        settle();
        check("rdp_count", n_valid - base, 1);
        check("rdp_code", key_code, 4'd6);
        check("rdp_held", key_held, 1'b1);

        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
